// File: rtl/alu_pkg.sv
// Shared opcode values, {N,Z,C,V} bit positions and FSM encoding for the ALU arbiter.
package alu_pkg;
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Settle cycles the shared ALU needs for a given opcode.
  function automatic logic [3:0] op_latency(input logic [3:0] op, input int mul_lat,
                                            input int other_lat);
    return (op == OP_MUL) ? 4'(mul_lat) : 4'(other_lat);
  endfunction
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a tie goes to the requester not granted last,
// a lone request is granted outright; the pointer only moves on i_accept.
module rr_arb2 (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  input  logic       i_accept,
  output logic [1:0] o_grant,
  output logic       o_id
);
  logic r_prio;

  always_comb begin
    o_id = 1'b0;
    case (i_req)
      2'b10:   o_id = 1'b1;
      2'b11:   o_id = r_prio;
      default: o_id = 1'b0;
    endcase
    o_grant = 2'b00;
    if (|i_req) o_grant[o_id] = 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_prio <= 1'b0;
    else if (i_accept) r_prio <= ~o_id;
  end
endmodule

// File: rtl/alu_arbiter.sv
// Sequences two requesters onto one shared ALU, one operation in flight: grant, wait
// MUL_LAT/OTHER_LAT settle cycles, capture, then hold the result until rsp_ready.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int MUL_LAT   = 2,
  parameter int OTHER_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [7:0]  req_opcode,
  input  logic [63:0] req_a,
  input  logic [63:0] req_b,
  input  logic [5:0]  req_sr_cont,
  input  logic [9:0]  req_sr_bit,
  input  logic [1:0]  req_setf,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic [3:0]  alu_opcode,
  output logic [2:0]  alu_sr_cont,
  output logic [4:0]  alu_sr_bit,
  input  logic [31:0] alu_out,
  input  logic [3:0]  alu_flags,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  output logic [3:0]  flags
);
  state_t      r_state, w_next;
  logic [3:0]  r_cnt;
  logic        r_id, r_setf;
  logic [31:0] r_in1, r_in2, r_data;
  logic [3:0]  r_opc, r_flags;
  logic [2:0]  r_sc;
  logic [4:0]  r_sb;

  logic [1:0]  w_grant;
  logic        w_gid, w_accept, w_setf;
  logic [3:0]  w_opc;
  logic [31:0] w_a, w_b;
  logic [2:0]  w_sc;
  logic [4:0]  w_sb;

  assign w_accept = (r_state == ST_IDLE) && (|req_valid);

  rr_arb2 u_rr (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_req    (req_valid),
    .i_accept (w_accept),
    .o_grant  (w_grant),
    .o_id     (w_gid)
  );

  assign w_opc  = w_gid ? req_opcode[7:4]   : req_opcode[3:0];
  assign w_a    = w_gid ? req_a[63:32]      : req_a[31:0];
  assign w_b    = w_gid ? req_b[63:32]      : req_b[31:0];
  assign w_sc   = w_gid ? req_sr_cont[5:3]  : req_sr_cont[2:0];
  assign w_sb   = w_gid ? req_sr_bit[9:5]   : req_sr_bit[4:0];
  assign w_setf = w_gid ? req_setf[1]       : req_setf[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (|req_valid) w_next = ST_EXEC;
      ST_EXEC: if (r_cnt == 4'd1) w_next = ST_RESP;
      ST_RESP: if (rsp_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // The handshake cycle is spent in RESP, so a new grant can never overlap it.
  always_comb begin
    req_ready = 2'b00;
    rsp_valid = 1'b0;
    case (r_state)
      ST_IDLE: req_ready = w_grant;
      ST_RESP: rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in1   <= '0;
      r_in2   <= '0;
      r_opc   <= '0;
      r_sc    <= '0;
      r_sb    <= '0;
      r_cnt   <= '0;
      r_id    <= 1'b0;
      r_setf  <= 1'b0;
      r_data  <= '0;
      r_flags <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_in1  <= w_a;
          r_in2  <= w_b;
          r_opc  <= w_opc;
          r_sc   <= w_sc;
          r_sb   <= w_sb;
          r_cnt  <= op_latency(w_opc, MUL_LAT, OTHER_LAT);
          r_id   <= w_gid;
          r_setf <= w_setf;
        end
        ST_EXEC: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_data <= alu_out;
            if (r_setf) r_flags <= alu_flags;
          end
        end
        default: ;
      endcase
    end
  end

  assign alu_in1     = r_in1;
  assign alu_in2     = r_in2;
  assign alu_opcode  = r_opc;
  assign alu_sr_cont = r_sc;
  assign alu_sr_bit  = r_sb;
  assign rsp_id      = r_id;
  assign rsp_data    = r_data;
  assign flags       = r_flags;
endmodule
